div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Sequencing controller for the multi-cycle DIV/DIVU path of the EX stage.
- Owns a radix-2 restoring shift-subtract divider plus the FSM around it.
- Raises a stall request while a division is in flight.
- Delivers {HI = remainder, LO = quotient} as a 64-bit write-data word with a one-cycle ok strobe.
- Handles divide-by-zero, downstream back-pressure and flush (annul) mid-operation.

Parameters:
DATA_W, 32, operand width; the result is 2*DATA_W bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous, active-high reset
start_i  input  1  EX holds a DIV/DIVU; sampled only in IDLE
signed_i  input  1  1 = DIV (two's complement), 0 = DIVU; captured with start_i
dividend_i  input  DATA_W  rs operand; captured with start_i
divisor_i  input  DATA_W  rt operand; captured with start_i
annul_i  input  1  flush (exception/ERET); aborts any operation
stall_i  input  1  downstream stall; holds a finished result
stall_req_o  output  1  request that IF/ID/EX stall
ok_o  output  1  wdata_o valid this cycle
wdata_o  output  2*DATA_W  {remainder, quotient}
busy_o  output  1  FSM not in IDLE

Behaviour:
- Reset (rst_i=1 at an edge): FSM to IDLE, counter 0, internal regs 0. Outputs: stall_req_o=0, ok_o=0, wdata_o=0, busy_o=0. rst_i has priority over every other input.
- FSM states: IDLE, DIVZERO, ON, END.
- IDLE:
  - If start_i=1, annul_i=0 and divisor_i=0: go to DIVZERO.
  - If start_i=1, annul_i=0 and divisor_i≠0: capture operands and go to ON.
  - For DIV, capture |dividend| and |divisor|, and record q_neg = sign(a) XOR sign(b) and r_neg = sign(a).
  - stall_req_o = start_i & ~annul_i, combinationally in IDLE, so the stall begins the same cycle the divide is seen.
- DIVZERO: one cycle, then go to END. Result is quotient = all ones, remainder = dividend_i (raw), for both DIV and DIVU.
- ON: one restoring step per cycle.
  - Partial remainder {r, q} shifts left 1; trial = r - divisor.
  - If the trial is non-negative, r takes the trial value and the q LSB is 1.
  - The counter increments from 0 to DATA_W-1; at DATA_W-1, sign fix-up is applied and the FSM goes to END.
  - Sign fix-up: negate q if q_neg; negate r if r_neg. Arithmetic is mod 2^DATA_W, so -2^31 / -1 gives q=0x80000000, r=0.
- END:
  - ok_o=1, wdata_o = {r, q}, stall_req_o=0.
  - If stall_i=0, go to IDLE next cycle.
  - If stall_i=1, stay in END with ok_o and wdata_o held stable.
- Latency:
  - Normal divide: start sampled at cycle 0; ON for cycles 1..DATA_W; END at cycle DATA_W+1 (33 for 32-bit).
  - Divide by zero: END at cycle 2.
- stall_req_o is 1 in DIVZERO and ON, and 0 in END and in IDLE unless start_i is asserted.
- wdata_o is 0 whenever ok_o=0.
- A back-to-back divide is accepted in IDLE the cycle after END; start_i is never sampled in END, so one instruction cannot double-issue.
- annul_i=1 in any state: go to IDLE next cycle, ok_o=0 and stall_req_o=0 in that cycle, no result produced. In IDLE it blocks start_i.
- Simultaneous annul_i and stall_i in END: annul wins.

Optional Feature:
- Macro: DIV_FAST_SMALL_EN.
- Defined: in IDLE, if divisor≠0 and |dividend| < |divisor| (unsigned compare of the magnitudes), skip ON and go directly to END. Result is quotient 0, remainder = dividend_i (raw, sign preserved). END is reached at cycle 1.
- Not defined: all nonzero divisors take the full DATA_W-cycle path. Results are identical in both builds; only latency differs.

Test Plan:
- DIVU 100/7: start at cycle 0 -> stall_req_o=1 for cycles 0..32; ok_o=1 at cycle 33; wdata_o=0x00000002_0000000E.
- DIV -7/2 (0xFFFFFFF9, 2) -> wdata_o={0xFFFFFFFF, 0xFFFFFFFD}. Also DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
- DIVU 5/0 -> ok_o at cycle 2, wdata_o={0x00000005, 0xFFFFFFFF}; stall_req_o=1 for cycles 0..1 only.
- DIVU 100/7 with annul_i=1 at cycle 10 -> IDLE at cycle 11; ok_o never asserted; a new DIVU 9/3 started at cycle 12 gives {0, 3} at cycle 45.
- Finish with stall_i=1 for 3 cycles in END -> ok_o and wdata_o held 4 cycles; IDLE after stall_i drops; start_i held high during END is not re-sampled.
- With DIV_FAST_SMALL_EN defined, DIVU 3/10 -> ok_o at cycle 1, {0x00000003, 0}. Without it -> same value at cycle 33.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl: sequencing controller for the multi-cycle DIV/DIVU path of EX.
// Radix-2 restoring shift-subtract divider plus its FSM. Produces
// {remainder, quotient} with a one-cycle ok strobe. The strobe is held while
// the downstream stage stalls.
// Optional build macro: DIV_FAST_SMALL_EN. When it is defined, a division
// where |dividend| < |divisor| finishes in one cycle.
module div_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     dividend_i,
    input  logic [DATA_W-1:0]     divisor_i,
    input  logic                  annul_i,
    input  logic                  stall_i,
    output logic                  stall_req_o,
    output logic                  ok_o,
    output logic [2*DATA_W-1:0]   wdata_o,
    output logic                  busy_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DIVZERO = 2'd1;
    localparam logic [1:0] S_ON      = 2'd2;
    localparam logic [1:0] S_END     = 2'd3;

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   dvsr;
    logic                q_neg;
    logic                r_neg;

    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;
    logic                fast_small;
    logic [DATA_W:0]     shifted;
    logic [DATA_W:0]     trial;
    logic [DATA_W-1:0]   step_rem;
    logic [DATA_W-1:0]   step_quo;
    logic [DATA_W-1:0]   fix_rem;
    logic [DATA_W-1:0]   fix_quo;
    logic                last_step;

    // Operand magnitudes. The magnitude of the most negative value wraps to
    // itself, which is still the correct unsigned magnitude.
    always_comb begin
        a_neg = signed_i & dividend_i[DATA_W-1];
        b_neg = signed_i & divisor_i[DATA_W-1];
        abs_a = a_neg ? (~dividend_i + 1'b1) : dividend_i;
        abs_b = b_neg ? (~divisor_i + 1'b1) : divisor_i;
    end

`ifdef DIV_FAST_SMALL_EN
    assign fast_small = (abs_a < abs_b);
`else
    assign fast_small = 1'b0;
`endif

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor,
    // and keep the difference only when it did not borrow.
    always_comb begin
        shifted   = {rem, quo[DATA_W-1]};
        trial     = shifted - {1'b0, dvsr};
        step_rem  = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
        step_quo  = {quo[DATA_W-2:0], ~trial[DATA_W]};
        fix_rem   = r_neg ? (~step_rem + 1'b1) : step_rem;
        fix_quo   = q_neg ? (~step_quo + 1'b1) : step_quo;
        last_step = (cnt == CNT_W'(DATA_W - 1));
    end

    // FSM and datapath registers. Reset takes priority, then annul.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvsr  <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (annul_i) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        cnt <= '0;
                        if (divisor_i == '0) begin
                            rem   <= dividend_i;
                            quo   <= '1;
                            state <= S_DIVZERO;
                        end else if (fast_small) begin
                            rem   <= dividend_i;
                            quo   <= '0;
                            state <= S_END;
                        end else begin
                            rem   <= '0;
                            quo   <= abs_a;
                            dvsr  <= abs_b;
                            q_neg <= a_neg ^ b_neg;
                            r_neg <= a_neg;
                            state <= S_ON;
                        end
                    end
                end
                S_DIVZERO: state <= S_END;
                S_ON: begin
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        rem   <= fix_rem;
                        quo   <= fix_quo;
                        state <= S_END;
                    end else begin
                        rem <= step_rem;
                        quo <= step_quo;
                    end
                end
                default: begin
                    if (!stall_i) state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs. Annul suppresses both the stall and the result in the same cycle.
    always_comb begin
        busy_o      = (state != S_IDLE);
        ok_o        = (state == S_END) & ~annul_i;
        wdata_o     = ok_o ? {rem, quo} : '0;
        stall_req_o = 1'b0;
        case (state)
            S_IDLE:    stall_req_o = start_i & ~annul_i;
            S_DIVZERO: stall_req_o = ~annul_i;
            S_ON:      stall_req_o = ~annul_i;
            default:   stall_req_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed and random checks of div_ctrl against an arithmetic
// reference model of DIV/DIVU results and latencies.
module tb_div_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        annul_i;
    logic        stall_i;
    logic        stall_req_o;
    logic        ok_o;
    logic [63:0] wdata_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .signed_i(signed_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .annul_i(annul_i),
        .stall_i(stall_i), .stall_req_o(stall_req_o), .ok_o(ok_o),
        .wdata_o(wdata_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, qq, rr;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            qq = sa / sb;
            rr = sa % sb;
            return {rr[31:0], qq[31:0]};
        end
        return {a % b, a / b};
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
        return (s && v[31]) ? (32'd0 - v) : v;
    endfunction

    function automatic int latency(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (b == 0) return 2;
`ifdef DIV_FAST_SMALL_EN
        if (mag(a, s) < mag(b, s)) return 1;
`endif
        return 33;
    endfunction

    // Issue one divide at the next cycle and follow it to completion.
    // hold = extra END cycles with stall_i high (start_i also held high);
    // kill = annul together with stall during END instead of a normal exit.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int hold, input bit kill);
        int cyc;
        bit done;
        logic [63:0] exp;
        exp = model(a, b, s);
        @(posedge clk_i); #1;
        start_i = 1'b1; dividend_i = a; divisor_i = b; signed_i = s;
        @(negedge clk_i);
        chk("stall_cycle0", {63'd0, stall_req_o}, 64'd1);
        @(posedge clk_i); #1;
        start_i = 1'b0; dividend_i = $urandom; divisor_i = $urandom; signed_i = 1'($urandom);
        cyc = 1; done = 0;
        while (!done) begin
            @(negedge clk_i);
            if (ok_o === 1'b1) begin
                done = 1;
            end else begin
                chk("stall_inflight", {63'd0, stall_req_o}, 64'd1);
                if (cyc >= 60) begin
                    chk("timeout_cycles", 64'(cyc), 64'(latency(a, b, s)));
                    return;
                end
                @(posedge clk_i); #1;
                cyc++;
            end
        end
        chk("latency", 64'(cyc), 64'(latency(a, b, s)));
        chk("wdata", wdata_o, exp);
        chk("stall_end", {63'd0, stall_req_o}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            stall_i = 1'b1; start_i = 1'b1;
            @(posedge clk_i); #1;
            @(negedge clk_i);
            chk("held_ok", {63'd0, ok_o}, 64'd1);
            chk("held_wdata", wdata_o, exp);
        end
        start_i = 1'b0;
        if (kill) begin
            stall_i = 1'b1;
            @(posedge clk_i); #1;
            annul_i = 1'b1;
            @(negedge clk_i);
            chk("annul_end_ok", {63'd0, ok_o}, 64'd0);
            chk("annul_end_wdata", wdata_o, 64'd0);
        end
        stall_i = 1'b0;
        @(posedge clk_i); #1;
        annul_i = 1'b0;
        @(negedge clk_i);
        chk("idle_busy", {63'd0, busy_o}, 64'd0);
        chk("idle_ok", {63'd0, ok_o}, 64'd0);
        chk("idle_wdata", wdata_o, 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic rs;
        rst_i = 1'b1; start_i = 1'b0; signed_i = 1'b0; dividend_i = '0;
        divisor_i = '0; annul_i = 1'b0; stall_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_busy", {63'd0, busy_o}, 64'd0);
        chk("reset_ok", {63'd0, ok_o}, 64'd0);
        chk("reset_stall", {63'd0, stall_req_o}, 64'd0);
        chk("reset_wdata", wdata_o, 64'd0);
        rst_i = 1'b0;

        run_div(32'd100, 32'd7, 1'b0, 0, 0);
        chk("divu_100_7", model(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
        run_div(32'd5, 32'd0, 1'b0, 0, 0);
        run_div(32'hFFFF_FFF0, 32'd0, 1'b1, 0, 0);
        run_div(32'd3, 32'd10, 1'b0, 0, 0);
        run_div(32'hFFFF_FFFD, 32'd10, 1'b1, 0, 0);
        run_div(32'd1000, 32'd33, 1'b0, 3, 0);
        run_div(32'd77, 32'd5, 1'b1, 1, 1);

        // Annul mid-division, then a fresh divide two cycles later.
        @(posedge clk_i); #1;
        start_i = 1'b1; dividend_i = 32'd100; divisor_i = 32'd7; signed_i = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
        end
        annul_i = 1'b1;
        @(negedge clk_i);
        chk("annul_stall", {63'd0, stall_req_o}, 64'd0);
        chk("annul_ok", {63'd0, ok_o}, 64'd0);
        @(posedge clk_i); #1;
        annul_i = 1'b0;
        @(negedge clk_i);
        chk("annul_idle", {63'd0, busy_o}, 64'd0);
        run_div(32'd9, 32'd3, 1'b0, 0, 0);

        // Annul in IDLE blocks start.
        @(posedge clk_i); #1;
        start_i = 1'b1; annul_i = 1'b1; divisor_i = 32'd3;
        @(negedge clk_i);
        chk("annul_idle_stall", {63'd0, stall_req_o}, 64'd0);
        @(posedge clk_i); #1;
        start_i = 1'b0; annul_i = 1'b0;
        @(negedge clk_i);
        chk("annul_blocks_start", {63'd0, busy_o}, 64'd0);

        // Synchronous reset mid-division.
        @(posedge clk_i); #1;
        start_i = 1'b1; dividend_i = 32'd50; divisor_i = 32'd3;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("midop_reset_busy", {63'd0, busy_o}, 64'd0);

        for (int n = 0; n < 16; n++) begin
            rs = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(3))
                0: rb = 32'd0;
                1: rb = $urandom_range(15);
                2: rb = 32'hFFFF_FFFF - $urandom_range(7);
                default: rb = $urandom;
            endcase
            if ($urandom_range(3) == 0) ra = $urandom_range(20);
            run_div(ra, rb, rs, $urandom_range(2), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
